// File: rtl/wb_regfile.sv
// wb_regfile: write-back select, 32x64 register file with x0 tied to zero, and retired-instruction counter.
// Define WB_BYPASS_EN to make a same-cycle write visible on the read ports.
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid,
  input  logic                    wb_memtoreg,
  input  logic                    wb_regwrite,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [XLEN-1:0]         wb_result,
  input  logic [XLEN-1:0]         wb_readdata,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic [XLEN-1:0]         wb_data,
  output logic                    wb_we,
  output logic [63:0]             instret
);
  logic [XLEN-1:0] regs [NREG];
  always_comb begin
    wb_data = wb_memtoreg ? wb_readdata : wb_result;
    wb_we   = wb_valid && wb_regwrite && (wb_rd != '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      instret <= '0;
    end else begin
      if (wb_we) regs[wb_rd] <= wb_data;
      if (wb_valid) instret <= instret + 64'd1;
    end
  end
  // reset gating keeps a bypassed wb_data off the read ports while in reset
`ifdef WB_BYPASS_EN
  always_comb begin
    rs1_data = (reset || rs1_addr == '0) ? '0 : (wb_we && rs1_addr == wb_rd) ? wb_data : regs[rs1_addr];
    rs2_data = (reset || rs2_addr == '0) ? '0 : (wb_we && rs2_addr == wb_rd) ? wb_data : regs[rs2_addr];
  end
`else
  always_comb begin
    rs1_data = (reset || rs1_addr == '0) ? '0 : regs[rs1_addr];
    rs2_data = (reset || rs2_addr == '0) ? '0 : regs[rs2_addr];
  end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile; expectations come from a reference register model.
module tb_wb_regfile;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic wb_valid = 1'b0, wb_memtoreg = 1'b0, wb_regwrite = 1'b0;
  logic [4:0] wb_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [63:0] wb_result = '0, wb_readdata = '0;
  logic [63:0] rs1_data, rs2_data, wb_data, instret;
  logic wb_we;
  typedef struct {string tag; int sel; logic [63:0] exp;} exp_t;
  exp_t sb[$];
  logic [63:0] mregs [32];
  logic [63:0] mcnt = '0;
  int n_vec = 0, n_err = 0;
  wb_regfile dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .wb_readdata(wb_readdata), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data), .wb_we(wb_we),
    .instret(instret)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] obs(input int sel);
    return sel == 0 ? wb_data : sel == 1 ? {63'd0, wb_we} : sel == 2 ? rs1_data : sel == 3 ? rs2_data : instret;
  endfunction
  function automatic logic [63:0] rd_model(input logic r, input logic [4:0] a, input logic we,
                                           input logic [4:0] rd, input logic [63:0] wd);
    return (r || a == 5'd0) ? 64'd0 : (BYP && we && a == rd) ? wd : mregs[a];
  endfunction
  task automatic cyc(input logic r, input logic v, input logic m, input logic w, input logic [4:0] rd,
                     input logic [63:0] res, input logic [63:0] rdat, input logic [4:0] a1,
                     input logic [4:0] a2, input string tag);
    logic we;
    logic [63:0] wd;
    exp_t e;
    @(negedge clk);
    reset = r; wb_valid = v; wb_memtoreg = m; wb_regwrite = w; wb_rd = rd;
    wb_result = res; wb_readdata = rdat; rs1_addr = a1; rs2_addr = a2;
    if (r) begin
      foreach (mregs[i]) mregs[i] = '0;
      mcnt = '0;
    end
    we = v && w && rd != 5'd0;
    wd = m ? rdat : res;
    sb.push_back('{{tag, "/wb_data"}, 0, wd});
    sb.push_back('{{tag, "/wb_we"}, 1, {63'd0, we}});
    sb.push_back('{{tag, "/rs1"}, 2, rd_model(r, a1, we, rd, wd)});
    sb.push_back('{{tag, "/rs2"}, 3, rd_model(r, a2, we, rd, wd)});
    sb.push_back('{{tag, "/instret"}, 4, mcnt});
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
    if (!r) begin
      if (we) mregs[rd] = wd;
      if (v) mcnt = mcnt + 64'd1;
    end
  endtask
  initial begin
    foreach (mregs[i]) mregs[i] = '0;
    cyc(1, 1, 0, 1, 5'd4, 64'h77, 64'h0, 5'd4, 5'd4, "rst_hold");
    cyc(0, 1, 0, 1, 5'd7, 64'hAAAA, 64'h5555, 5'd4, 5'd0, "sel_alu");
    cyc(0, 1, 1, 1, 5'd7, 64'hAAAA, 64'h5555, 5'd7, 5'd7, "sel_load");
    cyc(0, 1, 0, 1, 5'd0, '1, '1, 5'd7, 5'd0, "x0_wr");
    cyc(0, 1, 0, 1, 5'd3, 64'h11, 64'h0, 5'd0, 5'd0, "x3_wr");
    cyc(0, 0, 0, 1, 5'd3, 64'h99, 64'h0, 5'd3, 5'd0, "bubble");
    cyc(0, 1, 0, 1, 5'd9, 64'h1, 64'h0, 5'd3, 5'd0, "x9_init");
    cyc(0, 1, 0, 1, 5'd9, 64'hBEEF, 64'h0, 5'd9, 5'd9, "same_cyc");
    cyc(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd9, 5'd9, "after_wr");
    cyc(0, 1, 0, 1, 5'd5, 64'h1234, 64'h0, 5'd9, 5'd0, "x5_wr");
    cyc(1, 1, 0, 1, 5'd6, 64'h42, 64'h0, 5'd5, 5'd6, "mid_rst");
    cyc(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd5, 5'd6, "post_rst");
    for (int i = 0; i < 10; i++)
      cyc(0, 1, 0, i[0], 5'(i + 1), 64'(i * 3 + 1), 64'h0, 5'(i), 5'd0, "cnt");
    @(posedge clk);
    #1 check("instret_10", instret, 64'd10);
    wb_valid = 1'b0;
    force dut.instret = '1;
    #1 release dut.instret;
    mcnt = '1;
    cyc(0, 1, 0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0, "wrap_pre");
    cyc(0, 0, 0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0, "wrap_post");
    for (int i = 0; i < 40; i++)
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), {$urandom, $urandom},
          {$urandom, $urandom}, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rand");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
